// File: rtl/id_ex_stage.sv
// ID/EX pipeline register. It resolves the destination register, detects load-use and
// register-jump hazards, inserts bubbles, and counts stall and flush events.
module id_ex_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_reg_wr,
    input  logic             id_branch,
    input  logic             id_branch_ctrl,
    input  logic             id_jump,
    input  logic             id_jump_src,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             id_alu_src_a,
    input  logic             id_alu_src_b,
    input  logic             id_lui_op,
    input  logic             id_signed_op,
    input  logic             id_lwlb,
    input  logic [1:0]       id_mem_to_reg,
    input  logic [1:0]       id_reg_dst,
    input  logic [3:0]       id_alu_op,
    input  logic [31:0]      id_pc_plus4,
    input  logic [31:0]      id_rs_data,
    input  logic [31:0]      id_rt_data,
    input  logic [31:0]      id_imm_ext,
    input  logic [4:0]       id_shamt,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       id_rd,
    input  logic             mem_reg_wr,
    input  logic             mem_mem_read,
    input  logic [4:0]       mem_write_addr,
    input  logic             ex_flush,
    input  logic             hold,
    output logic             ex_reg_wr,
    output logic             ex_branch,
    output logic             ex_branch_ctrl,
    output logic             ex_jump,
    output logic             ex_jump_src,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_alu_src_a,
    output logic             ex_alu_src_b,
    output logic             ex_lui_op,
    output logic             ex_signed_op,
    output logic             ex_lwlb,
    output logic [1:0]       ex_mem_to_reg,
    output logic [1:0]       ex_reg_dst,
    output logic [3:0]       ex_alu_op,
    output logic [31:0]      ex_pc_plus4,
    output logic [31:0]      ex_rs_data,
    output logic [31:0]      ex_rt_data,
    output logic [31:0]      ex_imm_ext,
    output logic [4:0]       ex_shamt,
    output logic [4:0]       ex_rs,
    output logic [4:0]       ex_rt,
    output logic [4:0]       ex_rd,
    output logic [4:0]       ex_write_addr,
    output logic             ex_valid,
    output logic             stall,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic [4:0] dest;
    logic       uses_rs;
    logic       uses_rt;
    logic       load_use;
    logic       jr_vs_ex;
    logic       jr_vs_mem;
    logic       hazard;
    logic       load_id;
    logic       bubble;

    always_comb begin
        dest = 5'd0;
        case (id_reg_dst)
            2'b00:   dest = id_rd;
            2'b01:   dest = id_rt;
            2'b10:   dest = 5'd31;
            default: dest = 5'd0;
        endcase
    end

    // Direct jumps (j/jal) read no registers; jr/jalr read rs.
    assign uses_rs = !id_alu_src_a && !(id_jump && !id_jump_src);
    assign uses_rt = (!id_alu_src_b || id_mem_write) && !(id_jump && !id_jump_src);

    assign load_use = ex_valid && ex_mem_read && (ex_write_addr != 5'd0) &&
                      (((ex_write_addr == id_rs) && uses_rs) ||
                       ((ex_write_addr == id_rt) && uses_rt));
    assign jr_vs_ex  = id_jump && id_jump_src && ex_valid && ex_reg_wr &&
                       (ex_write_addr != 5'd0) && (ex_write_addr == id_rs);
    assign jr_vs_mem = id_jump && id_jump_src && mem_mem_read && mem_reg_wr &&
                       (mem_write_addr != 5'd0) && (mem_write_addr == id_rs);
    assign hazard    = load_use || jr_vs_ex || jr_vs_mem;

    assign stall   = hold || (!ex_flush && hazard);
    assign load_id = !hold && !ex_flush && !hazard;
    assign bubble  = !hold && !load_id;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_reg_wr      <= 1'b0;
            ex_branch      <= 1'b0;
            ex_branch_ctrl <= 1'b0;
            ex_jump        <= 1'b0;
            ex_jump_src    <= 1'b0;
            ex_mem_read    <= 1'b0;
            ex_mem_write   <= 1'b0;
            ex_alu_src_a   <= 1'b0;
            ex_alu_src_b   <= 1'b0;
            ex_lui_op      <= 1'b0;
            ex_signed_op   <= 1'b0;
            ex_lwlb        <= 1'b0;
            ex_mem_to_reg  <= 2'd0;
            ex_reg_dst     <= 2'd0;
            ex_alu_op      <= 4'd0;
            ex_pc_plus4    <= 32'd0;
            ex_rs_data     <= 32'd0;
            ex_rt_data     <= 32'd0;
            ex_imm_ext     <= 32'd0;
            ex_shamt       <= 5'd0;
            ex_rs          <= 5'd0;
            ex_rt          <= 5'd0;
            ex_rd          <= 5'd0;
            ex_write_addr  <= 5'd0;
            ex_valid       <= 1'b0;
        end else if (!hold) begin
            // Bubble and load share one path: every field is gated by load_id.
            ex_reg_wr      <= load_id & id_reg_wr;
            ex_branch      <= load_id & id_branch;
            ex_branch_ctrl <= load_id & id_branch_ctrl;
            ex_jump        <= load_id & id_jump;
            ex_jump_src    <= load_id & id_jump_src;
            ex_mem_read    <= load_id & id_mem_read;
            ex_mem_write   <= load_id & id_mem_write;
            ex_alu_src_a   <= load_id & id_alu_src_a;
            ex_alu_src_b   <= load_id & id_alu_src_b;
            ex_lui_op      <= load_id & id_lui_op;
            ex_signed_op   <= load_id & id_signed_op;
            ex_lwlb        <= load_id & id_lwlb;
            ex_mem_to_reg  <= load_id ? id_mem_to_reg : 2'd0;
            ex_reg_dst     <= load_id ? id_reg_dst    : 2'd0;
            ex_alu_op      <= load_id ? id_alu_op     : 4'd0;
            ex_pc_plus4    <= load_id ? id_pc_plus4   : 32'd0;
            ex_rs_data     <= load_id ? id_rs_data    : 32'd0;
            ex_rt_data     <= load_id ? id_rt_data    : 32'd0;
            ex_imm_ext     <= load_id ? id_imm_ext    : 32'd0;
            ex_shamt       <= load_id ? id_shamt      : 5'd0;
            ex_rs          <= load_id ? id_rs         : 5'd0;
            ex_rt          <= load_id ? id_rt         : 5'd0;
            ex_rd          <= load_id ? id_rd         : 5'd0;
            ex_write_addr  <= load_id ? dest          : 5'd0;
            ex_valid       <= load_id;
        end
    end

    // Saturating event counters; a flush always outranks a hazard.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (bubble) begin
            if (ex_flush) begin
                if (flush_cnt != {CNT_W{1'b1}}) flush_cnt <= flush_cnt + 1'b1;
            end else begin
                if (stall_cnt != {CNT_W{1'b1}}) stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, pass-through, hazards, flush, hold, saturation.
// A second instance with 2-bit counters shares the stimulus so that saturation is reachable.
module tb_id_ex_stage;

    logic clk, reset;
    logic id_reg_wr, id_branch, id_branch_ctrl, id_jump, id_jump_src, id_mem_read, id_mem_write;
    logic id_alu_src_a, id_alu_src_b, id_lui_op, id_signed_op, id_lwlb;
    logic [1:0] id_mem_to_reg, id_reg_dst;
    logic [3:0] id_alu_op;
    logic [31:0] id_pc_plus4, id_rs_data, id_rt_data, id_imm_ext;
    logic [4:0] id_shamt, id_rs, id_rt, id_rd;
    logic mem_reg_wr, mem_mem_read, ex_flush, hold;
    logic [4:0] mem_write_addr;

    logic ex_reg_wr, ex_branch, ex_branch_ctrl, ex_jump, ex_jump_src, ex_mem_read, ex_mem_write;
    logic ex_alu_src_a, ex_alu_src_b, ex_lui_op, ex_signed_op, ex_lwlb, ex_valid, stall;
    logic [1:0] ex_mem_to_reg, ex_reg_dst;
    logic [3:0] ex_alu_op;
    logic [31:0] ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm_ext;
    logic [4:0] ex_shamt, ex_rs, ex_rt, ex_rd, ex_write_addr;
    logic [15:0] stall_cnt, flush_cnt;

    logic s_reg_wr, s_branch, s_branch_ctrl, s_jump, s_jump_src, s_mem_read, s_mem_write;
    logic s_alu_src_a, s_alu_src_b, s_lui_op, s_signed_op, s_lwlb, s_valid, s_stall;
    logic [1:0] s_mem_to_reg, s_reg_dst;
    logic [3:0] s_alu_op;
    logic [31:0] s_pc_plus4, s_rs_data, s_rt_data, s_imm_ext;
    logic [4:0] s_shamt, s_rs, s_rt, s_rd, s_write_addr;
    logic [1:0] s_stall_cnt, s_flush_cnt;

    int n_tests = 0;
    int n_fail = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    id_ex_stage #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .id_reg_wr(id_reg_wr), .id_branch(id_branch), .id_branch_ctrl(id_branch_ctrl),
        .id_jump(id_jump), .id_jump_src(id_jump_src), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_alu_src_a(id_alu_src_a), .id_alu_src_b(id_alu_src_b),
        .id_lui_op(id_lui_op), .id_signed_op(id_signed_op), .id_lwlb(id_lwlb),
        .id_mem_to_reg(id_mem_to_reg), .id_reg_dst(id_reg_dst), .id_alu_op(id_alu_op),
        .id_pc_plus4(id_pc_plus4), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm_ext(id_imm_ext), .id_shamt(id_shamt), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .mem_reg_wr(mem_reg_wr), .mem_mem_read(mem_mem_read), .mem_write_addr(mem_write_addr),
        .ex_flush(ex_flush), .hold(hold),
        .ex_reg_wr(ex_reg_wr), .ex_branch(ex_branch), .ex_branch_ctrl(ex_branch_ctrl),
        .ex_jump(ex_jump), .ex_jump_src(ex_jump_src), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_alu_src_a(ex_alu_src_a), .ex_alu_src_b(ex_alu_src_b),
        .ex_lui_op(ex_lui_op), .ex_signed_op(ex_signed_op), .ex_lwlb(ex_lwlb),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_dst(ex_reg_dst), .ex_alu_op(ex_alu_op),
        .ex_pc_plus4(ex_pc_plus4), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
        .ex_imm_ext(ex_imm_ext), .ex_shamt(ex_shamt), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_write_addr(ex_write_addr), .ex_valid(ex_valid), .stall(stall),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    id_ex_stage #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset),
        .id_reg_wr(id_reg_wr), .id_branch(id_branch), .id_branch_ctrl(id_branch_ctrl),
        .id_jump(id_jump), .id_jump_src(id_jump_src), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_alu_src_a(id_alu_src_a), .id_alu_src_b(id_alu_src_b),
        .id_lui_op(id_lui_op), .id_signed_op(id_signed_op), .id_lwlb(id_lwlb),
        .id_mem_to_reg(id_mem_to_reg), .id_reg_dst(id_reg_dst), .id_alu_op(id_alu_op),
        .id_pc_plus4(id_pc_plus4), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm_ext(id_imm_ext), .id_shamt(id_shamt), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .mem_reg_wr(mem_reg_wr), .mem_mem_read(mem_mem_read), .mem_write_addr(mem_write_addr),
        .ex_flush(ex_flush), .hold(hold),
        .ex_reg_wr(s_reg_wr), .ex_branch(s_branch), .ex_branch_ctrl(s_branch_ctrl),
        .ex_jump(s_jump), .ex_jump_src(s_jump_src), .ex_mem_read(s_mem_read),
        .ex_mem_write(s_mem_write), .ex_alu_src_a(s_alu_src_a), .ex_alu_src_b(s_alu_src_b),
        .ex_lui_op(s_lui_op), .ex_signed_op(s_signed_op), .ex_lwlb(s_lwlb),
        .ex_mem_to_reg(s_mem_to_reg), .ex_reg_dst(s_reg_dst), .ex_alu_op(s_alu_op),
        .ex_pc_plus4(s_pc_plus4), .ex_rs_data(s_rs_data), .ex_rt_data(s_rt_data),
        .ex_imm_ext(s_imm_ext), .ex_shamt(s_shamt), .ex_rs(s_rs), .ex_rt(s_rt), .ex_rd(s_rd),
        .ex_write_addr(s_write_addr), .ex_valid(s_valid), .stall(s_stall),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_id();
        {id_reg_wr, id_branch, id_branch_ctrl, id_jump, id_jump_src, id_mem_read} = '0;
        {id_mem_write, id_alu_src_a, id_alu_src_b, id_lui_op, id_signed_op, id_lwlb} = '0;
        id_mem_to_reg = 2'd0; id_reg_dst = 2'd0; id_alu_op = 4'd0;
        id_pc_plus4 = 32'h0000_0400; id_imm_ext = 32'd0; id_shamt = 5'd0;
        id_rs = 5'd0; id_rt = 5'd0; id_rd = 5'd0;
        id_rs_data = 32'd0; id_rt_data = 32'd0;
    endtask

    task automatic clear_mem();
        mem_reg_wr = 1'b0; mem_mem_read = 1'b0; mem_write_addr = 5'd0;
    endtask

    // addu rd, rs, rt
    task automatic set_alu(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        clear_id();
        id_reg_wr = 1'b1; id_reg_dst = 2'b00; id_alu_op = 4'd0;
        id_rd = rd; id_rs = rs; id_rt = rt;
        id_rs_data = 32'hA000_0000 | 32'(rs); id_rt_data = 32'hB000_0000 | 32'(rt);
    endtask

    // lw rt, 4(rs)
    task automatic set_lw(input logic [4:0] rt, input logic [4:0] rs);
        clear_id();
        id_reg_wr = 1'b1; id_mem_read = 1'b1; id_alu_src_b = 1'b1;
        id_reg_dst = 2'b01; id_mem_to_reg = 2'b01; id_imm_ext = 32'd4;
        id_rt = rt; id_rs = rs; id_rs_data = 32'hA000_0000 | 32'(rs);
    endtask

    // jr rs
    task automatic set_jr(input logic [4:0] rs);
        clear_id();
        id_jump = 1'b1; id_jump_src = 1'b1; id_alu_src_b = 1'b1;
        id_rs = rs; id_rs_data = 32'hA000_0000 | 32'(rs);
    endtask

    task automatic test_reset();
        logic [31:0] rs_d;
        logic [4:0] exp_dest;
        reset = 1'b0; ex_flush = 1'b0; hold = 1'b0; clear_mem();
        clear_id();
        {id_reg_wr, id_branch, id_mem_read, id_signed_op} = 4'($urandom_range(0, 15));
        id_reg_dst = 2'($urandom_range(0, 3)); id_alu_op = 4'($urandom_range(0, 15));
        id_rs_data = $urandom; id_rt_data = $urandom; id_imm_ext = $urandom;
        id_rs = 5'($urandom_range(1, 31)); id_rt = 5'($urandom_range(1, 31));
        id_rd = 5'($urandom_range(1, 31));
        repeat (3) step();
        n_tests++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b exp 0", ex_valid); end
        n_tests++; if (ex_write_addr !== 5'd0) begin n_fail++; $display("FAIL reset_waddr: got %0d exp 0", ex_write_addr); end
        n_tests++; if ({ex_rs_data, ex_rt_data, ex_imm_ext} !== 96'd0) begin n_fail++; $display("FAIL reset_data: got %0h exp 0", {ex_rs_data, ex_rt_data, ex_imm_ext}); end
        n_tests++; if ({ex_reg_wr, ex_mem_read, ex_alu_op, ex_reg_dst} !== 8'd0) begin n_fail++; $display("FAIL reset_ctrl: got %0h exp 0", {ex_reg_wr, ex_mem_read, ex_alu_op, ex_reg_dst}); end
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0b exp 0", stall); end
        n_tests++; if ({stall_cnt, flush_cnt, s_stall_cnt, s_flush_cnt} !== 36'd0) begin n_fail++; $display("FAIL reset_cnt: got %0h exp 0", {stall_cnt, flush_cnt}); end
        rs_d = id_rs_data;
        case (id_reg_dst)
            2'b00:   exp_dest = id_rd;
            2'b01:   exp_dest = id_rt;
            2'b10:   exp_dest = 5'd31;
            default: exp_dest = 5'd0;
        endcase
        @(negedge clk); reset = 1'b1;
        step();
        n_tests++; if (ex_valid !== 1'b1) begin n_fail++; $display("FAIL release_valid: got %0b exp 1", ex_valid); end
        n_tests++; if (ex_rs_data !== rs_d) begin n_fail++; $display("FAIL release_rs_data: got %0h exp %0h", ex_rs_data, rs_d); end
        n_tests++; if (ex_write_addr !== exp_dest) begin n_fail++; $display("FAIL release_waddr: got %0d exp %0d", ex_write_addr, exp_dest); end
    endtask

    task automatic test_pass_through();
        set_alu(5'd8, 5'd9, 5'd10);
        #1;
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL pass_stall: got %0b exp 0", stall); end
        step();
        n_tests++; if (ex_write_addr !== 5'd8) begin n_fail++; $display("FAIL pass_waddr: got %0d exp 8", ex_write_addr); end
        n_tests++; if ({ex_reg_wr, ex_valid, ex_alu_op} !== 6'b11_0000) begin n_fail++; $display("FAIL pass_ctrl: got %0b exp 110000", {ex_reg_wr, ex_valid, ex_alu_op}); end
        n_tests++; if ({ex_rs_data, ex_rt_data} !== {32'hA000_0009, 32'hB000_000A}) begin n_fail++; $display("FAIL pass_data: got %0h exp a0000009b000000a", {ex_rs_data, ex_rt_data}); end
        n_tests++; if ({ex_rs, ex_rt, ex_rd} !== {5'd9, 5'd10, 5'd8}) begin n_fail++; $display("FAIL pass_fields: got %0h exp %0h", {ex_rs, ex_rt, ex_rd}, {5'd9, 5'd10, 5'd8}); end
    endtask

    task automatic test_dest();
        logic [1:0] dst_tab [4];
        logic [4:0] exp_tab [4];
        dst_tab = '{2'b00, 2'b01, 2'b10, 2'b11};
        exp_tab = '{5'd5, 5'd6, 5'd31, 5'd0};
        for (int i = 0; i < 4; i++) begin
            set_alu(5'd5, 5'd7, 5'd6);
            id_reg_dst = dst_tab[i];
            step();
            n_tests++; if (ex_write_addr !== exp_tab[i]) begin n_fail++; $display("FAIL dest_%0d: got %0d exp %0d", i, ex_write_addr, exp_tab[i]); end
        end
    endtask

    task automatic test_load_use();
        set_lw(5'd8, 5'd2);
        step();
        set_alu(5'd9, 5'd8, 5'd2);
        #1;
        n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall: got %0b exp 1", stall); end
        step(); exp_stall++;
        n_tests++; if ({ex_valid, ex_write_addr, ex_reg_wr} !== 7'd0) begin n_fail++; $display("FAIL lu_bubble: got %0h exp 0", {ex_valid, ex_write_addr, ex_reg_wr}); end
        n_tests++; if (stall_cnt !== 16'(exp_stall)) begin n_fail++; $display("FAIL lu_cnt: got %0d exp %0d", stall_cnt, exp_stall); end
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_release: got %0b exp 0", stall); end
        step();
        n_tests++; if ({ex_valid, ex_write_addr} !== {1'b1, 5'd9}) begin n_fail++; $display("FAIL lu_enter: got %0h exp %0h", {ex_valid, ex_write_addr}, {1'b1, 5'd9}); end
    endtask

    task automatic test_jr_hazards();
        set_lw(5'd31, 5'd2);
        step();
        set_jr(5'd31);
        #1;
        n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL jrl_stall1: got %0b exp 1", stall); end
        step(); exp_stall++;
        mem_reg_wr = 1'b1; mem_mem_read = 1'b1; mem_write_addr = 5'd31;
        #1;
        n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL jrl_stall2: got %0b exp 1", stall); end
        step(); exp_stall++;
        clear_mem();
        #1;
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL jrl_release: got %0b exp 0", stall); end
        n_tests++; if (stall_cnt !== 16'(exp_stall)) begin n_fail++; $display("FAIL jrl_cnt: got %0d exp %0d", stall_cnt, exp_stall); end
        step();
        n_tests++; if ({ex_valid, ex_jump, ex_jump_src} !== 3'b111) begin n_fail++; $display("FAIL jrl_enter: got %0b exp 111", {ex_valid, ex_jump, ex_jump_src}); end
        set_alu(5'd31, 5'd9, 5'd10);
        step();
        set_jr(5'd31);
        #1;
        n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL jra_stall1: got %0b exp 1", stall); end
        step(); exp_stall++;
        mem_reg_wr = 1'b1; mem_mem_read = 1'b0; mem_write_addr = 5'd31;
        #1;
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL jra_release: got %0b exp 0", stall); end
        step();
        clear_mem();
        n_tests++; if ({ex_valid, ex_jump} !== 2'b11) begin n_fail++; $display("FAIL jra_enter: got %0b exp 11", {ex_valid, ex_jump}); end
        n_tests++; if (stall_cnt !== 16'(exp_stall)) begin n_fail++; $display("FAIL jra_cnt: got %0d exp %0d", stall_cnt, exp_stall); end
    endtask

    task automatic test_flush();
        set_lw(5'd8, 5'd2);
        step();
        set_alu(5'd9, 5'd8, 5'd2);
        ex_flush = 1'b1;
        #1;
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL fl_stall: got %0b exp 0", stall); end
        step(); exp_flush++;
        ex_flush = 1'b0;
        n_tests++; if ({ex_valid, ex_write_addr} !== 6'd0) begin n_fail++; $display("FAIL fl_bubble: got %0h exp 0", {ex_valid, ex_write_addr}); end
        n_tests++; if (flush_cnt !== 16'(exp_flush)) begin n_fail++; $display("FAIL fl_cnt: got %0d exp %0d", flush_cnt, exp_flush); end
        n_tests++; if (stall_cnt !== 16'(exp_stall)) begin n_fail++; $display("FAIL fl_stall_cnt: got %0d exp %0d", stall_cnt, exp_stall); end
        step();
        n_tests++; if ({ex_valid, ex_write_addr} !== {1'b1, 5'd9}) begin n_fail++; $display("FAIL fl_enter: got %0h exp %0h", {ex_valid, ex_write_addr}, {1'b1, 5'd9}); end
    endtask

    task automatic test_zero_reg();
        set_lw(5'd0, 5'd2);
        step();
        set_alu(5'd9, 5'd0, 5'd0);
        #1;
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL zero_lu: got %0b exp 0", stall); end
        step();
        set_jr(5'd0);
        mem_reg_wr = 1'b1; mem_mem_read = 1'b1; mem_write_addr = 5'd0;
        #1;
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL zero_jr: got %0b exp 0", stall); end
        step();
        clear_mem();
        n_tests++; if ({ex_valid, ex_jump} !== 2'b11) begin n_fail++; $display("FAIL zero_enter: got %0b exp 11", {ex_valid, ex_jump}); end
    endtask

    task automatic test_hold();
        set_alu(5'd12, 5'd13, 5'd14);
        hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ex_flush = (i == 2);
            #1;
            n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL hold_stall_%0d: got %0b exp 1", i, stall); end
            step();
            n_tests++; if ({ex_valid, ex_jump, ex_rs_data} !== {2'b11, 32'hA000_0000}) begin n_fail++; $display("FAIL hold_regs_%0d: got %0h exp %0h", i, {ex_valid, ex_jump, ex_rs_data}, {2'b11, 32'hA000_0000}); end
            n_tests++; if ({stall_cnt, flush_cnt} !== {16'(exp_stall), 16'(exp_flush)}) begin n_fail++; $display("FAIL hold_cnt_%0d: got %0h exp %0h", i, {stall_cnt, flush_cnt}, {16'(exp_stall), 16'(exp_flush)}); end
        end
        hold = 1'b0; ex_flush = 1'b0;
    endtask

    task automatic test_saturation();
        int exp_sat;
        set_jr(5'd31);
        mem_reg_wr = 1'b1; mem_mem_read = 1'b1; mem_write_addr = 5'd31;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL sat_stall_%0d: got %0b exp 1", i, stall); end
            step(); exp_stall++;
            exp_sat = (exp_stall > 3) ? 3 : exp_stall;
            n_tests++; if (stall_cnt !== 16'(exp_stall)) begin n_fail++; $display("FAIL sat_cnt16_%0d: got %0d exp %0d", i, stall_cnt, exp_stall); end
            n_tests++; if (s_stall_cnt !== 2'(exp_sat)) begin n_fail++; $display("FAIL sat_cnt2_%0d: got %0d exp %0d", i, s_stall_cnt, exp_sat); end
        end
        clear_mem();
    endtask

    task automatic test_reset_mid_stall();
        set_lw(5'd8, 5'd2);
        step();
        set_alu(5'd9, 5'd8, 5'd2);
        #1;
        n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL mid_pre_stall: got %0b exp 1", stall); end
        reset = 1'b0;
        #1;
        exp_stall = 0; exp_flush = 0;
        n_tests++; if ({stall, ex_valid, ex_mem_read, ex_write_addr} !== 8'd0) begin n_fail++; $display("FAIL mid_clear: got %0h exp 0", {stall, ex_valid, ex_mem_read, ex_write_addr}); end
        n_tests++; if ({stall_cnt, flush_cnt} !== 32'd0) begin n_fail++; $display("FAIL mid_cnt: got %0h exp 0", {stall_cnt, flush_cnt}); end
        #1;
        reset = 1'b1;
        step();
        n_tests++; if ({ex_valid, ex_write_addr} !== {1'b1, 5'd9}) begin n_fail++; $display("FAIL mid_enter: got %0h exp %0h", {ex_valid, ex_write_addr}, {1'b1, 5'd9}); end
        n_tests++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_no_stall: got %0d exp 0", stall_cnt); end
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_dest();
        test_load_use();
        test_jr_hazards();
        test_flush();
        test_zero_reg();
        test_hold();
        test_saturation();
        test_reset_mid_stall();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline boundary of the five-stage MIPS pipeline. It sits directly downstream of the instruction decoder.
- Registers the decoder's control bundle and the ID-stage operands into the EX stage.
- Resolves the destination register and detects load-use and register-jump hazards against the EX and MEM stages.
- Inserts bubbles, freezes PC and IF/ID, and counts stall and flush events.

Parameters:
- CNT_W, 16, width of the saturating stall and flush event counters.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_reg_wr, id_branch, id_branch_ctrl, id_jump, id_jump_src, id_mem_read, id_mem_write, id_alu_src_a, id_alu_src_b, id_lui_op, id_signed_op, id_lwlb  in  1 each  decoder controls.
- id_mem_to_reg  in  2  decoder control.
- id_reg_dst  in  2  decoder control: 00 rd, 01 rt, 10 $31.
- id_alu_op  in  4  decoder control.
- id_pc_plus4, id_rs_data, id_rt_data, id_imm_ext  in  32 each  ID-stage operands.
- id_shamt, id_rs, id_rt, id_rd  in  5 each  instruction fields.
- mem_reg_wr, mem_mem_read  in  1 each  MEM-stage controls.
- mem_write_addr  in  5  MEM-stage destination register.
- ex_flush  in  1  branch taken in EX; the ID instruction is wrong-path.
- hold  in  1  external freeze (memory wait).
- ex_* outputs  out  same widths as the id_* inputs above  registered copies, e.g. ex_alu_op 4, ex_rs_data 32.
- ex_write_addr  out  5  resolved destination register.
- ex_valid  out  1  EX holds a real instruction.
- stall  out  1  freeze PC and IF/ID this cycle.
- stall_cnt, flush_cnt  out  CNT_W each  event counters.

Behaviour:
- Reset (reset=0, asynchronous): every registered output is 0. This is a NOP; ex_write_addr=0 and both counters=0.
- Destination resolution (combinational): dest = rd for RegDst 00, rt for 01, 31 for 10, 0 for 11.
- uses_rs = !id_alu_src_a && !(id_jump && !id_jump_src).
- uses_rt = (!id_alu_src_b || id_mem_write) && !(id_jump && !id_jump_src).
- A hazard exists if any of the following holds:
  - Load-use: ex_valid && ex_mem_read && ex_write_addr!=0, and ex_write_addr matches id_rs with uses_rs, or matches id_rt with uses_rt.
  - Register jump vs EX: id_jump && id_jump_src && ex_valid && ex_reg_wr && ex_write_addr!=0 && ex_write_addr==id_rs.
  - Register jump vs MEM load: id_jump && id_jump_src && mem_mem_read && mem_reg_wr && mem_write_addr!=0 && mem_write_addr==id_rs.
  - Consequences: a load feeding jr yields 2 consecutive bubbles; an ALU result feeding jr yields 1.
- Per-cycle priority at the rising edge:
  1. hold=1: all ex_* registers and counters keep their values; stall=1.
  2. else ex_flush=1: load a bubble; stall=0; flush_cnt++. Flush wins over any hazard.
  3. else hazard: load a bubble; stall=1; stall_cnt++.
  4. else: load the id_* inputs, ex_write_addr=dest, ex_valid=1; stall=0.
- Bubble: every ex_* control and data field is 0, ex_write_addr=0, ex_valid=0.
- stall is combinational, from hold, ex_flush and the hazard terms only; no dependence on clk within the cycle.
- Latency: one cycle from id_* to ex_*. A stalled instruction re-presents unchanged on id_* the next cycle.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Register $0 never creates a hazard.
- Reset asserted mid-stall clears all state. The first cycle after release behaves as if EX holds a NOP, so no hazard is seen from EX.

Test Plan:
- Reset: hold reset=0 for 3 cycles with random id_* inputs -> all ex_* =0, ex_valid=0, stall=0, counters=0. After release, the next edge loads id_*.
- Pass-through: addu $8,$9,$10 (id_reg_dst=00, id_rd=8, id_alu_op=0) -> next cycle ex_write_addr=8, ex_alu_op=0, ex_reg_wr=1, ex_valid=1, stall=0.
- Load-use: lw $8 in EX, then ID add $9,$8,$2 -> stall=1 for exactly 1 cycle, one bubble, stall_cnt=1; the add enters EX the following cycle.
- Load feeding jr: lw $31 then jr $31 -> stall=1 for 2 cycles (EX rule, then MEM rule), stall_cnt=2; the jr enters EX on the third edge. With an addu $31 instead -> 1 stall.
- Flush vs hazard: load-use condition plus ex_flush=1 in the same cycle -> bubble, stall=0, flush_cnt=1, stall_cnt unchanged.
- Hold and saturation: hold=1 for 5 cycles -> ex_* and counters frozen, stall=1. With CNT_W=2, force 5 hazards -> stall_cnt stays at 3.
